// File: rtl/fpu_pkg.sv
// Shared FPU definitions: normalize-stage FSM states, fp32 constants and packed format.
package fpu_pkg;

    localparam int EXP_W_DEFAULT  = 10;
    localparam int MANT_W_DEFAULT = 23;
    localparam int FP32_BIAS      = 127;
    localparam int FP32_EXP_MAX   = 255;

    typedef enum logic [1:0] {
        NR_Idle,
        NR_Norm,
        NR_Round,
        NR_Hold
    } NormState;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational fraction rounder. FPMUL_RNE_EN defined: round-to-nearest-even;
// undefined: truncation, where guard/sticky are ignored and carry is always 0.
module fp_round_rne
    import fpu_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEFAULT
) (
    input  logic [MANT_W-1:0] frac_in,
    input  logic              guard,
    input  logic              sticky,
    output logic [MANT_W-1:0] frac_out,
    output logic              carry
);

`ifdef FPMUL_RNE_EN
    logic round_up;

    assign round_up          = guard & (sticky | frac_in[0]);
    // An all-ones fraction wraps to zero here; the carry bumps the exponent upstream.
    assign {carry, frac_out} = {1'b0, frac_in} + {{MANT_W{1'b0}}, round_up};
`else
    logic unused_round;

    assign unused_round = guard | sticky;
    assign frac_out     = frac_in;
    assign carry        = 1'b0;
`endif

endmodule

// File: rtl/fp_mul_normround.sv
// Normalize/round/pack stage of the fp32 multiplier with a valid/ack output hold.
// Rounding mode selected by FPMUL_RNE_EN (defined: RNE, undefined: truncate).
module fp_mul_normround
    import fpu_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEFAULT,
    parameter int MANT_W = MANT_W_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RSTK,
    input  logic [2*MANT_W+1:0]     prod_in,
    input  logic signed [EXP_W-1:0] exp_in,
    input  logic                    sign_in,
    input  logic                    in_valid,
    output logic [31:0]             out_result,
    output logic                    out_valid,
    input  logic                    out_ack,
    output logic                    out_ovf,
    output logic                    out_unf,
    output logic                    overrun,
    output logic                    busy
);

    localparam int PROD_W = 2 * MANT_W + 2;

    NormState                state;
    logic [PROD_W-1:0]       prod_r;
    logic signed [EXP_W-1:0] exp_r;
    logic                    sign_r;
    logic [MANT_W-1:0]       frac_r;
    logic                    guard_r;
    logic                    sticky_r;

    logic [MANT_W-1:0]       frac_rnd;
    logic                    carry;
    logic signed [EXP_W-1:0] exp_rnd;
    fp32_t                   pack;
    logic                    ovf_next;
    logic                    unf_next;

    fp_round_rne #(
        .MANT_W (MANT_W)
    ) u_round (
        .frac_in  (frac_r),
        .guard    (guard_r),
        .sticky   (sticky_r),
        .frac_out (frac_rnd),
        .carry    (carry)
    );

    assign exp_rnd = exp_r + $signed({{(EXP_W-1){1'b0}}, carry});

    // Zero product wins over the range checks so it never raises a flag.
    always_comb begin
        pack.sign = sign_r;
        pack.exp  = '0;
        pack.frac = '0;
        ovf_next  = 1'b0;
        unf_next  = 1'b0;
        if (prod_r != '0) begin
            if (exp_rnd >= EXP_W'(FP32_EXP_MAX)) begin
                pack.exp = '1;
                ovf_next = 1'b1;
            end else if (exp_rnd <= EXP_W'(0)) begin
                unf_next = 1'b1;
            end else begin
                pack.exp  = exp_rnd[7:0];
                pack.frac = frac_rnd;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTK) begin
        if (!RSTK) begin
            state      <= NR_Idle;
            prod_r     <= '0;
            exp_r      <= '0;
            sign_r     <= 1'b0;
            frac_r     <= '0;
            guard_r    <= 1'b0;
            sticky_r   <= 1'b0;
            out_result <= '0;
            out_valid  <= 1'b0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (in_valid && state != NR_Idle) begin
                overrun <= 1'b1;
            end
            case (state)
                NR_Idle: begin
                    if (in_valid) begin
                        prod_r <= prod_in;
                        exp_r  <= exp_in;
                        sign_r <= sign_in;
                        busy   <= 1'b1;
                        state  <= NR_Norm;
                    end
                end
                NR_Norm: begin
                    if (prod_r[PROD_W-1]) begin
                        frac_r   <= prod_r[PROD_W-2 -: MANT_W];
                        guard_r  <= prod_r[PROD_W-2-MANT_W];
                        sticky_r <= |prod_r[PROD_W-3-MANT_W:0];
                        exp_r    <= exp_r + EXP_W'(1);
                    end else begin
                        frac_r   <= prod_r[PROD_W-3 -: MANT_W];
                        guard_r  <= prod_r[PROD_W-3-MANT_W];
                        sticky_r <= |prod_r[PROD_W-4-MANT_W:0];
                    end
                    state <= NR_Round;
                end
                NR_Round: begin
                    out_result <= pack;
                    out_ovf    <= ovf_next;
                    out_unf    <= unf_next;
                    out_valid  <= 1'b1;
                    state      <= NR_Hold;
                end
                NR_Hold: begin
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        out_ovf   <= 1'b0;
                        out_unf   <= 1'b0;
                        busy      <= 1'b0;
                        state     <= NR_Idle;
                    end
                end
                default: state <= NR_Idle;
            endcase
        end
    end

endmodule
